bram_stream_writer: RTL
=======================

Name: bram_stream_writer

Overview:
- Fills one RAMB18E2, in x9 mode, from a byte stream that uses a valid/ready handshake.
- Writes land at consecutive addresses starting from a commanded base, with modulo wrap.
- A second BRAM port provides a 1-cycle-latency read-back path.
- This is the write-side producer for the BRAM lookup tables that the rom blocks read.

Parameters:
AW, 8, byte address width, legal range 1..11 (x9 mode holds 2048 entries).

Ports:
clock  in  1  sole clock; both BRAM ports run on it.
reset  in  1  asynchronous, active-high reset.
start  in  1  command strobe; sampled only in IDLE.
base  in  AW  first write address, latched on start.
len  in  AW+1  number of bytes to write, latched on start.
in_valid  in  1  input byte valid.
in_data  in  8  input byte.
in_ready  out  1  high exactly while state==WRITE.
busy  out  1  high in WRITE and FLUSH.
done  out  1  one-cycle completion pulse.
count  out  AW+1  bytes accepted in the current/last command.
sum  out  8  mod-256 sum of bytes accepted in the current/last command.
rd_addr  in  AW  read-back address on port A.
rd_data  out  8  read-back data, 1-cycle latency.

Behaviour:
- Reset values: state=IDLE; in_ready, busy, done = 0; count, sum, write pointer = 0; write-stage enable = 0.
- rd_data is forced to 0 by BRAM synchronous reset (RSTRAMARSTRAM=reset, SRVAL_A=0) at every edge while reset is high. It is the only output not cleared asynchronously.
- BRAM configuration:
  - CLOCK_DOMAINS "COMMON"; DOA_REG/DOB_REG = 0.
  - READ_WIDTH_A = 9, WRITE_WIDTH_B = 9; all INIT = 0.
  - Port B address = {(11-AW) zeros, ptr, 3'b000}; DINBDIN = {8'h00, data}; WEBWE = {4{wr_en}}; ENBWREN = wr_en.
  - Port A address uses the same mapping on rd_addr; ENARDEN = 1; rd_data = DOUTADOUT[7:0].
- States: IDLE, WRITE, FLUSH.
- IDLE:
  - start with len=0: done=1 in the next cycle, stays IDLE, no writes, count=0, sum=0.
  - start with len>0: go to WRITE; ptr=base, remaining=len, count=0, sum=0.
  - in_valid is ignored in IDLE.
- WRITE:
  - A beat is accepted at each edge with in_valid && in_ready.
  - On acceptance: the write-stage register captures {ptr, in_data} and sets wr_en=1 for the next cycle, so the BRAM commits at the following edge.
  - Also on acceptance: ptr = ptr+1 mod 2^AW; remaining decrements; count increments; sum = sum+in_data mod 256.
  - Back-to-back beats are accepted with no bubbles.
  - When the last beat (remaining==1) is accepted, go to FLUSH.
- FLUSH: lasts one cycle, during which the last write commits. Then go to IDLE and assert done for exactly one cycle.
- Read-after-write: any rd_addr sampled at the edge where done is high, or later, returns the new data.
- Reading an address on port A at the same edge port B writes it is undefined; bench must avoid it.
- start while busy is ignored; base and len do not change mid-command.
- len > 2^AW: the pointer keeps wrapping and earlier bytes are overwritten; count still ends at len.
- Reset mid-command:
  - The FSM returns to IDLE immediately.
  - A beat held in the write stage but not yet committed is dropped.
  - Already-committed BRAM contents are retained and never cleared by reset.
- count and sum hold their final values in IDLE until the next start.

Test Plan:
- Reset, then read addr 0x05 -> rd_data=0x00 one cycle later; busy=0, in_ready=0.
- start base=0x10 len=4, feed A1,A2,A3,A4 back-to-back -> in_ready high 4 cycles, FLUSH 1 cycle, done 1 cycle. count=4, sum=0x8A; read-back 0x10..0x13 = A1,A2,A3,A4.
- start base=0xFE len=3, data 01,02,03 -> mem[FE]=01, mem[FF]=02, mem[00]=03; count=3, sum=0x06.
- start len=5 with in_valid toggling every other cycle, data 10..14 -> only handshaked beats counted, no duplicates. done appears 2 cycles after the 5th acceptance; sum=0x5A.
- start len=0 -> done next cycle, busy never high, count=0, sum=0, memory unchanged.
- base=0x20 len=4; assert reset after the edge accepting beat 2 and before the next edge -> mem[20]=beat1, mem[21] unchanged. State IDLE, in_ready=0, count=0 immediately.

Source files
------------

// File: rtl/bram_stream_writer_if.sv
`default_nettype none
// Byte stream handshake into bram_stream_writer.
interface bram_stream_writer_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input  in_ready);
  modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface
`default_nettype wire

// File: rtl/bram_stream_writer.sv
`default_nettype none
// bram_stream_writer: fills one x9 block RAM from a byte stream at consecutive
// wrapping addresses, with a 1-cycle read-back port. Rev 1.0
module bram_stream_writer #(
  parameter int AW = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [AW-1:0]         base,
  input  logic [AW:0]           len,
  bram_stream_writer_if.slave   s_in,
  output logic                  busy,
  output logic                  done,
  output logic [AW:0]           count,
  output logic [7:0]            sum,
  input  logic [AW-1:0]         rd_addr,
  output logic [7:0]            rd_data
);

  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, FLUSH = 2'd2} state_t;

  state_t        state_q, state_d;
  logic          in_ready_q, in_ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   rem_q, rem_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    sum_q, sum_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          accept;

  assign accept = s_in.in_valid && in_ready_q;

  always_comb begin
    state_d    = state_q;
    in_ready_d = in_ready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ptr_d      = ptr_q;
    rem_d      = rem_q;
    count_d    = count_q;
    sum_d      = sum_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          count_d = '0;
          sum_d   = '0;
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d    = WRITE;
            in_ready_d = 1'b1;
            busy_d     = 1'b1;
            ptr_d      = base;
            rem_d      = len;
          end
        end
      end
      WRITE: begin
        if (accept) begin
          // Stage the beat; the RAM commits it on the following edge.
          wr_en_d   = 1'b1;
          wr_addr_d = ptr_q;
          wr_data_d = s_in.in_data;
          ptr_d     = ptr_q + AW'(1);
          rem_d     = rem_q - (AW+1)'(1);
          count_d   = count_q + (AW+1)'(1);
          sum_d     = sum_q + s_in.in_data;
          if (rem_q == (AW+1)'(1)) begin
            state_d    = FLUSH;
            in_ready_d = 1'b0;
          end
        end
      end
      FLUSH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: begin
        state_d    = IDLE;
        in_ready_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ptr_q      <= '0;
      rem_q      <= '0;
      count_q    <= '0;
      sum_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      count_q    <= count_d;
      sum_q      <= sum_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign s_in.in_ready = in_ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign count         = count_q;
  assign sum           = sum_q;

`ifdef USE_RAMB18E2
  logic [15:0] doa;
  RAMB18E2 #(
    .CLOCK_DOMAINS ("COMMON"),
    .DOA_REG       (0),
    .DOB_REG       (0),
    .READ_WIDTH_A  (9),
    .WRITE_WIDTH_B (9),
    .SRVAL_A       (9'h000)
  ) u_ram (
    .CLKARDCLK     (clock),
    .CLKBWRCLK     (clock),
    .ENARDEN       (1'b1),
    .ENBWREN       (wr_en_q),
    .REGCEAREGCE   (1'b1),
    .REGCEB        (1'b0),
    .RSTRAMARSTRAM (reset),
    .RSTRAMB       (1'b0),
    .RSTREGARSTREG (1'b0),
    .RSTREGB       (1'b0),
    .ADDRENA       (1'b1),
    .ADDRENB       (1'b1),
    .SLEEP         (1'b0),
    .ADDRARDADDR   ({{(11-AW){1'b0}}, rd_addr, 3'b000}),
    .ADDRBWRADDR   ({{(11-AW){1'b0}}, wr_addr_q, 3'b000}),
    .DINADIN       (16'h0000),
    .DINBDIN       ({8'h00, wr_data_q}),
    .DINPADINP     (2'b00),
    .DINPBDINP     (2'b00),
    .WEA           (2'b00),
    .WEBWE         ({4{wr_en_q}}),
    .DOUTADOUT     (doa),
    .DOUTBDOUT     (),
    .DOUTPADOUTP   (),
    .DOUTPBDOUTP   ()
  );
  assign rd_data = doa[7:0];
`else
  // Inferred equivalent of the x9 RAMB18E2 above; contents are never reset.
  logic [7:0] mem [2**AW];
  logic [7:0] rd_data_q;

  always_ff @(posedge clock) begin
    if (wr_en_q) begin
      mem[wr_addr_q] <= wr_data_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data_q <= 8'h00;
    end else begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;
`endif

endmodule
`default_nettype wire
